// File: rtl/clkgen_prog_pkg.sv
// Shared types and constants for the DCM_CLKGEN run-time programming sequencer.
// Command words go out LSB first: the 2-bit prefix, then the 8-bit value.
package clkgen_prog_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_LOAD_D    = 4'd1,
      ST_GAP_D     = 4'd2,
      ST_LOAD_M    = 4'd3,
      ST_GAP_M     = 4'd4,
      ST_GO        = 4'd5,
      ST_WAIT_DONE = 4'd6,
      ST_WAIT_LOCK = 4'd7,
      ST_ERR       = 4'd8
   } state_e;

   localparam logic [1:0] CMD_LOAD_D = 2'b01;
   localparam logic [1:0] CMD_LOAD_M = 2'b11;
   localparam logic       CMD_GO     = 1'b0;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_PARAM    = 2'b01;
   localparam logic [1:0] ERR_DONE_TMO = 2'b10;
   localparam logic [1:0] ERR_LOCK_TMO = 2'b11;

   localparam logic [3:0] CMD_LEN = 4'd10;

   // Bit idx of the serial command word {val, cmd}.
   function automatic logic cmd_bit(input logic [1:0] cmd, input logic [7:0] val,
                                    input logic [3:0] idx);
      logic [9:0] word;
      word = {val, cmd};
      return (idx < CMD_LEN) ? word[idx] : 1'b0;
   endfunction

endpackage

// File: rtl/clkgen_sync2.sv
// Generic two-flop synchroniser for a single asynchronous level input.
module clkgen_sync2 (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/clkgen_prog_ctrl.sv
// Serialises LoadD / LoadM / GO onto the DCM_CLKGEN PROG port, then waits for
// PROGDONE and LOCKED with a saturating timeout. All outputs come from flops.
module clkgen_prog_ctrl
   import clkgen_prog_pkg::*;
#(
   parameter int TIMEOUT_W  = 16,
   parameter int GAP_CYCLES = 2
) (
   input  logic       wb_clk_i,
   input  logic       rst_n_i,
   input  logic       start_i,
   input  logic [7:0] m_i,
   input  logic [7:0] d_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o,
   output logic [1:0] err_code_o,
   output logic       prog_en_o,
   output logic       prog_data_o,
   input  logic       progdone_i,
   input  logic       locked_i
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [TIMEOUT_W-1:0] TMO_MAX  = {TIMEOUT_W{1'b1}};
   localparam logic [TIMEOUT_W-1:0] TMO_ONE  = TIMEOUT_W'(1'b1);

   state_e               state_q, state_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
   logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d, tmo_inc_s;
   logic [7:0]           m_enc_q, m_enc_d, d_enc_q, d_enc_d;
   logic                 accept_s, progdone_sync_s, locked_sync_s;
   logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [1:0]           err_code_q, err_code_d;
   logic                 prog_en_q, prog_en_d, prog_data_q, prog_data_d;

   clkgen_sync2 u_sync_progdone (
      .clk_i   (wb_clk_i),
      .rst_n_i (rst_n_i),
      .d_i     (progdone_i),
      .q_o     (progdone_sync_s)
   );

   clkgen_sync2 u_sync_locked (
      .clk_i   (wb_clk_i),
      .rst_n_i (rst_n_i),
      .d_i     (locked_i),
      .q_o     (locked_sync_s)
   );

   assign tmo_inc_s = (tmo_cnt_q == TMO_MAX) ? TMO_MAX : tmo_cnt_q + TMO_ONE;

   // State, counters, latched ratio and output flops.
   always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 4'd0;
         gap_cnt_q   <= {GAP_W{1'b0}};
         tmo_cnt_q   <= {TIMEOUT_W{1'b0}};
         m_enc_q     <= 8'd0;
         d_enc_q     <= 8'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= ERR_NONE;
         prog_en_q   <= 1'b0;
         prog_data_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         m_enc_q     <= m_enc_d;
         d_enc_q     <= d_enc_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
         prog_en_q   <= prog_en_d;
         prog_data_q <= prog_data_d;
      end
   end

   // Next-state logic; counters fall back to zero whenever a phase ends.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = 4'd0;
      gap_cnt_d = {GAP_W{1'b0}};
      tmo_cnt_d = {TIMEOUT_W{1'b0}};
      m_enc_d   = m_enc_q;
      d_enc_d   = d_enc_q;
      accept_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               accept_s = 1'b1;
               m_enc_d  = m_i - 8'd1;
               d_enc_d  = d_i - 8'd1;
               if ((m_i < 8'd2) || (d_i == 8'd0)) begin
                  state_d = ST_ERR;
               end else begin
                  state_d = ST_LOAD_D;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD_D, ST_LOAD_M: begin
            if (bit_cnt_q == CMD_LEN - 4'd1) begin
               state_d = (state_q == ST_LOAD_D) ? ST_GAP_D : ST_GAP_M;
            end else begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         ST_GAP_D, ST_GAP_M: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d = (state_q == ST_GAP_D) ? ST_LOAD_M : ST_GO;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1'b1);
            end
         end
         ST_GO:        state_d = ST_WAIT_DONE;
         ST_WAIT_DONE: begin
            if (progdone_sync_s) begin
               state_d = ST_WAIT_LOCK;
            end else if (tmo_inc_s == TMO_MAX) begin
               state_d = ST_ERR;
            end else begin
               tmo_cnt_d = tmo_inc_s;
            end
         end
         ST_WAIT_LOCK: begin
            if (locked_sync_s) begin
               state_d = ST_IDLE;
            end else if (tmo_inc_s == TMO_MAX) begin
               state_d = ST_ERR;
            end else begin
               tmo_cnt_d = tmo_inc_s;
            end
         end
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode from the upcoming state so the flops line up with it.
   // busy stays high through the ERR cycle and drops as ERR returns to IDLE.
   always_comb begin
      prog_en_d   = 1'b0;
      prog_data_d = 1'b0;
      case (state_d)
         ST_LOAD_D: begin
            prog_en_d   = 1'b1;
            prog_data_d = cmd_bit(CMD_LOAD_D, d_enc_d, bit_cnt_d);
         end
         ST_LOAD_M: begin
            prog_en_d   = 1'b1;
            prog_data_d = cmd_bit(CMD_LOAD_M, m_enc_d, bit_cnt_d);
         end
         ST_GO: begin
            prog_en_d   = 1'b1;
            prog_data_d = CMD_GO;
         end
         default: begin
            prog_en_d   = 1'b0;
            prog_data_d = 1'b0;
         end
      endcase
      busy_d     = (state_d != ST_IDLE);
      done_d     = (state_q == ST_WAIT_LOCK) && (state_d == ST_IDLE);
      err_d      = err_q;
      err_code_d = err_code_q;
      if (state_d == ST_ERR) begin
         err_d = 1'b1;
         case (state_q)
            ST_IDLE:      err_code_d = ERR_PARAM;
            ST_WAIT_DONE: err_code_d = ERR_DONE_TMO;
            ST_WAIT_LOCK: err_code_d = ERR_LOCK_TMO;
            default:      err_code_d = err_code_q;
         endcase
      end else if (accept_s) begin
         err_d      = 1'b0;
         err_code_d = ERR_NONE;
      end else begin
         err_d      = err_q;
         err_code_d = err_code_q;
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign err_code_o  = err_code_q;
   assign prog_en_o   = prog_en_q;
   assign prog_data_o = prog_data_q;

endmodule

// File: tb/tb_clkgen_prog_ctrl.sv
// Bench for clkgen_prog_ctrl: directed and random programming sequences checked
// cycle by cycle against a timeline model built from the sequencing rules.
module tb_clkgen_prog_ctrl;

   localparam int TW    = 4;
   localparam int GAP   = 2;
   localparam int TMO   = (1 << TW) - 1;
   localparam int NEVER = 1000;
   localparam int HMAX  = 100;

   logic       wb_clk = 1'b0;
   logic       rst_n, start, progdone, locked;
   logic [7:0] m_v, d_v;
   logic       busy, done, err, prog_en, prog_data;
   logic [1:0] err_code;

   int total_cnt = 0;
   int bad_cnt   = 0;
   int done_cyc;

   bit         e_busy [HMAX];
   bit         e_done [HMAX];
   bit         e_err  [HMAX];
   logic [1:0] e_code [HMAX];
   bit         e_en   [HMAX];
   bit         e_data [HMAX];
   bit         prior_err;
   logic [1:0] prior_code;

   always #5 wb_clk = ~wb_clk;

   clkgen_prog_ctrl #(.TIMEOUT_W(TW), .GAP_CYCLES(GAP)) dut (
      .wb_clk_i    (wb_clk),
      .rst_n_i     (rst_n),
      .start_i     (start),
      .m_i         (m_v),
      .d_i         (d_v),
      .busy_o      (busy),
      .done_o      (done),
      .err_o       (err),
      .err_code_o  (err_code),
      .prog_en_o   (prog_en),
      .prog_data_o (prog_data),
      .progdone_i  (progdone),
      .locked_i    (locked)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      if (obs !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_idle_from(input int from, input bit e, input logic [1:0] code);
      for (int c = from; c < HMAX; c++) begin
         e_busy[c] = 1'b0; e_done[c] = 1'b0; e_err[c] = e; e_code[c] = code;
         e_en[c]   = 1'b0; e_data[c] = 1'b0;
      end
   endtask

   // Expected outputs for cycles 0..last, with start seen in cycle 0.
   // pd / lk: first cycle progdone_i / locked_i are driven high (held high).
   task automatic build_model(input int m, input int d, input int pd, input int lk,
                              output int last);
      int dv, mv, go_cyc, e_cyc, s_cyc, l_cyc, t_cyc, err_at, mbase;
      logic [1:0] code;
      set_idle_from(0, prior_err, prior_code);
      if (m < 2 || d == 0) begin
         e_busy[1] = 1'b1; e_err[1] = 1'b1; e_code[1] = 2'b01;
         set_idle_from(2, 1'b1, 2'b01);
         prior_err = 1'b1; prior_code = 2'b01;
         last = 4;
      end else begin
         dv = (d - 1) & 255;
         mv = (m - 1) & 255;
         for (int c = 1; c < HMAX; c++) begin
            e_busy[c] = 1'b1; e_err[c] = 1'b0; e_code[c] = 2'b00;
         end
         mbase = 11 + GAP;
         for (int i = 0; i < 10; i++) begin
            e_en[1 + i]     = 1'b1;
            e_data[1 + i]   = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : bit'((dv >> (i - 2)) & 1);
            e_en[mbase + i] = 1'b1;
            e_data[mbase + i] = (i < 2) ? 1'b1 : bit'((mv >> (i - 2)) & 1);
         end
         go_cyc = 21 + 2 * GAP;
         e_en[go_cyc] = 1'b1; e_data[go_cyc] = 1'b0;
         e_cyc = go_cyc + 1;
         s_cyc = (pd + 2 > e_cyc) ? pd + 2 : e_cyc;
         err_at = -1;
         code   = 2'b00;
         if (s_cyc <= e_cyc + TMO - 1) begin
            l_cyc = s_cyc + 1;
            t_cyc = (lk + 2 > l_cyc) ? lk + 2 : l_cyc;
            if (t_cyc <= l_cyc + TMO - 1) begin
               set_idle_from(t_cyc + 1, 1'b0, 2'b00);
               e_done[t_cyc + 1] = 1'b1;
               prior_err = 1'b0; prior_code = 2'b00;
               last = t_cyc + 3;
            end else begin
               err_at = l_cyc + TMO; code = 2'b11;
            end
         end else begin
            err_at = e_cyc + TMO; code = 2'b10;
         end
         if (err_at >= 0) begin
            e_err[err_at] = 1'b1; e_code[err_at] = code;
            set_idle_from(err_at + 1, 1'b1, code);
            prior_err = 1'b1; prior_code = code;
            last = err_at + 3;
         end
      end
   endtask

   task automatic run_seq(input int m, input int d, input int pd, input int lk, input bit poke);
      int  last;
      bit  pk;
      pk = poke && (m >= 2) && (d != 0);
      build_model(m, d, pd, lk, last);
      done_cyc = -1;
      for (int c = 0; c <= last; c++) begin
         @(posedge wb_clk); #1;
         if (c == 0) begin
            start = 1'b1; m_v = 8'(m); d_v = 8'(d);
         end else begin
            start = pk && (c == 5 || c == 20);
            m_v = 8'($urandom); d_v = 8'($urandom);
         end
         progdone = (c >= pd);
         locked   = (c >= lk);
         @(negedge wb_clk);
         if (done && done_cyc < 0) done_cyc = c;
         check_eq($sformatf("m%0d_d%0d_cyc%0d", m, d, c),
                  {busy, done, err, err_code, prog_en, prog_data},
                  {e_busy[c], e_done[c], e_err[c], e_code[c], e_en[c], e_data[c]});
      end
      @(posedge wb_clk); #1;
      start = 1'b0; progdone = 1'b0; locked = 1'b0;
      repeat (3) @(posedge wb_clk);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; m_v = 8'd0; d_v = 8'd0;
      progdone = 1'b0; locked = 1'b0;
      prior_err = 1'b0; prior_code = 2'b00;
      repeat (3) @(posedge wb_clk);
      @(negedge wb_clk);
      check_eq("reset_outs", {busy, done, err, err_code, prog_en, prog_data}, 7'd0);
      @(posedge wb_clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge wb_clk);

      run_seq(8, 5, 30, 40, 1'b1);
      check_eq("done_cycle", done_cyc, 43);
      run_seq(1, 4, NEVER, NEVER, 1'b0);
      run_seq(3, 0, NEVER, NEVER, 1'b0);
      run_seq(8, 5, NEVER, NEVER, 1'b0);
      run_seq(20, 7, 30, NEVER, 1'b0);
      run_seq(8, 5, 30, 40, 1'b0);
      run_seq(100, 9, 38, 50, 1'b0);
      run_seq(100, 9, 39, 50, 1'b0);
      run_seq(255, 1, 30, 45, 1'b1);
      run_seq(2, 255, 30, 46, 1'b0);

      // Reset in the middle of LOAD_M.
      @(posedge wb_clk); #1;
      start = 1'b1; m_v = 8'd8; d_v = 8'd5;
      for (int c = 1; c <= 14; c++) begin
         @(posedge wb_clk); #1 start = 1'b0;
      end
      @(negedge wb_clk);
      check_eq("pre_rst_en", prog_en, 1'b1);
      @(posedge wb_clk); #1 rst_n = 1'b0;
      #1 check_eq("rst_mid_outs", {busy, done, err, err_code, prog_en, prog_data}, 7'd0);
      @(posedge wb_clk);
      @(posedge wb_clk); #1 rst_n = 1'b1;
      @(negedge wb_clk);
      check_eq("rst_rel_idle", {busy, done, err, err_code, prog_en, prog_data}, 7'd0);
      prior_err = 1'b0; prior_code = 2'b00;
      repeat (2) @(posedge wb_clk);
      run_seq(12, 3, 31, 35, 1'b1);

      for (int k = 0; k < 16; k++) begin
         int m, d, pd, lk;
         m  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 255));
         d  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
         pd = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(15, 40));
         lk = ($urandom_range(0, 5) == 0) ? NEVER : pd + int'($urandom_range(0, 18));
         run_seq(m, d, pd, lk, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
